// File: rtl/mdu_div_pkg.sv
// Shared types and width-dependent constants for the iterative RV32M divide unit.
package mdu_div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'd0,
      OP_DIVU = 2'd1,
      OP_REM  = 2'd2,
      OP_REMU = 2'd3
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_MAX_WIDTH = 64;

   // Built bit by bit so a full-width request never needs an out-of-range shift.
   function automatic logic [DIV_MAX_WIDTH-1:0] div_all_ones(input int width);
      logic [DIV_MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < DIV_MAX_WIDTH; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [DIV_MAX_WIDTH-1:0] div_min_neg(input int width);
      logic [DIV_MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < DIV_MAX_WIDTH; i++) begin
         if (i == width - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/mdu_div_div_core_unsigned.sv
// Unsigned radix-2 restoring divider: WIDTH steps after start, done high during the last step.
module div_core_unsigned
   import mdu_div_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    count_q;
   logic             running_q;

   logic [WIDTH:0]   rem_shift;
   logic             fits;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   // The partial remainder stays below the divisor, so only the shifted
   // comparand needs the extra bit; the subtraction result always fits WIDTH.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      fits      = (rem_shift >= {1'b0, dvs_q});
      rem_step  = fits ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
      quo_step  = {quo_q[WIDTH-2:0], fits};
   end

   assign done      = running_q && (count_q == '0);
   assign quotient  = quo_step;
   assign remainder = rem_step;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         count_q   <= '0;
         running_q <= 1'b0;
      end else if (start) begin
         rem_q     <= '0;
         quo_q     <= dividend;
         dvs_q     <= divisor;
         count_q   <= CW'(WIDTH - 1);
         running_q <= 1'b1;
      end else if (running_q) begin
         rem_q <= rem_step;
         quo_q <= quo_step;
         if (count_q == '0) running_q <= 1'b0;
         else               count_q   <= count_q - CW'(1);
      end
   end

endmodule

// File: rtl/mdu_div.sv
// RV32M divide unit: sign handling, RISC-V special cases, FSM and valid/ready handshake
// around the unsigned iterative core.
module mdu_div
   import mdu_div_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   localparam logic [WIDTH-1:0] DIV_ALL_ONES = WIDTH'(div_all_ones(WIDTH));
   localparam logic [WIDTH-1:0] DIV_MIN_NEG  = WIDTH'(div_min_neg(WIDTH));

   div_state_t       state;
   div_state_t       state_next;
   div_op_t          op_in;
   logic             is_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             div_zero;
   logic             overflow;
   logic             special;
   logic [WIDTH-1:0] special_y;
   logic             accept;
   logic             start;

   logic             is_rem_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic [WIDTH-1:0] y_q;

   logic             core_done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic [WIDTH-1:0] fixed_y;

   // Operand decode; only meaningful in the accept cycle.
   always_comb begin
      op_in     = div_op_t'(op);
      is_signed = (op_in == OP_DIV) || (op_in == OP_REM);
      a_neg     = is_signed && a[WIDTH-1];
      b_neg     = is_signed && b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      div_zero  = (b == '0);
      overflow  = is_signed && (a == DIV_MIN_NEG) && (b == DIV_ALL_ONES);
      special   = div_zero || overflow;
      special_y = '0;
      if (div_zero)      special_y = op[1] ? a : DIV_ALL_ONES;
      else if (overflow) special_y = (op_in == OP_DIV) ? a : '0;
      accept    = in_valid && in_ready && !flush;
      start     = accept && !special;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)    state_next = special ? DONE : BUSY;
         BUSY:    if (core_done) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign y         = y_q;

   assign fixed_y = is_rem_q ? (neg_rem_q ? -remainder : remainder)
                             : (neg_quo_q ? -quotient  : quotient);

   // Result register: loaded with the special result at accept, or with the
   // sign-corrected core result on the final step, then held through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         y_q       <= '0;
      end else if (accept) begin
         is_rem_q  <= op[1];
         neg_quo_q <= (op_in == OP_DIV) && (a_neg != b_neg);
         neg_rem_q <= (op_in == OP_REM) && a_neg;
         if (special) y_q <= special_y;
      end else if ((state == BUSY) && core_done && !flush) begin
         y_q <= fixed_y;
      end
   end

   div_core_unsigned #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .clear     (flush),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (core_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed RV32M cases, special results,
// backpressure, abort, and random back-to-back traffic against a reference model.
module tb_mdu_div;
   import mdu_div_pkg::*;

   localparam int WIDTH = 32;
   localparam int NORMAL_LAT = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             busy;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   mdu_div #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   // Reference RISC-V divide semantics, written independently of the RTL datapath.
   function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
      logic signed [WIDTH-1:0] sx;
      logic signed [WIDTH-1:0] sz;
      sx = $signed(x);
      sz = $signed(z);
      if (z == '0) return o[1] ? x : '1;
      if (!o[0] && x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return o[1] ? '0 : x;
      case (o)
         2'd0:    return $unsigned(sx / sz);
         2'd1:    return x / z;
         2'd2:    return $unsigned(sx % sz);
         default: return x % z;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one accept cycle, then scramble the operands to show they are not re-sampled.
   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
      op       = o;
      a        = x;
      b        = z;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      op       = 2'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic wait_out(output int lat, output bit rdy_seen);
      lat      = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready || !busy) rdy_seen = 1'b1;
         step();
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_flags: got rdy/ov/busy=%b expected 100", {in_ready, out_valid, busy});
      end
      checks++;
      if (y !== '0) begin
         errors++;
         $display("[TB] FAIL reset_y: got %h expected 0", y);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_unsigned();
      logic [1:0]       ops[3];
      logic [WIDTH-1:0] as[3];
      logic [WIDTH-1:0] bs[3];
      logic [WIDTH-1:0] exps[3];
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      ops = '{OP_DIVU, OP_REMU, OP_DIVU};
      as  = '{32'd100, 32'd100, 32'hFFFF_FFFF};
      bs  = '{32'd7, 32'd7, 32'd16};
      exps = '{32'd14, 32'd2, 32'h0FFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exps[i]);
         issue(ops[i], as[i], bs[i]);
         wait_out(lat, rdy_seen);
         e = exp_q.pop_front();
         checks++;
         if (y !== e) begin
            errors++;
            $display("[TB] FAIL unsigned_y[%0d]: got %h expected %h", i, y, e);
         end
         checks++;
         if (lat != NORMAL_LAT || rdy_seen) begin
            errors++;
            $display("[TB] FAIL unsigned_lat[%0d]: got %0d (ready_in_busy=%0b) expected %0d (0)",
                     i, lat, rdy_seen, NORMAL_LAT);
         end
         release_out();
      end
   endtask

   task automatic test_signed();
      logic [1:0]       ops[3];
      logic [WIDTH-1:0] as[3];
      logic [WIDTH-1:0] bs[3];
      logic [WIDTH-1:0] exps[3];
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      ops  = '{OP_DIV, OP_REM, OP_REM};
      as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
      bs   = '{32'd2, 32'd2, 32'hFFFF_FFFE};
      exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exps[i]);
         issue(ops[i], as[i], bs[i]);
         wait_out(lat, rdy_seen);
         e = exp_q.pop_front();
         checks++;
         if (y !== e || lat != NORMAL_LAT) begin
            errors++;
            $display("[TB] FAIL signed[%0d]: got y=%h lat=%0d expected y=%h lat=%0d",
                     i, y, lat, e, NORMAL_LAT);
         end
         release_out();
      end
   endtask

   task automatic test_div_zero();
      logic [1:0]       ops[4];
      logic [WIDTH-1:0] exps[4];
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      ops  = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      exps = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hBADC_AFFE, 32'hBADC_AFFE};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         issue(ops[i], 32'hBADC_AFFE, 32'd0);
         wait_out(lat, rdy_seen);
         e = exp_q.pop_front();
         checks++;
         if (y !== e || lat != 1) begin
            errors++;
            $display("[TB] FAIL div_zero[%0d]: got y=%h lat=%0d expected y=%h lat=1", i, y, lat, e);
         end
         release_out();
      end
   endtask

   task automatic test_overflow();
      logic [1:0]       ops[4];
      logic [WIDTH-1:0] exps[4];
      int               lats[4];
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      ops  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
      exps = '{32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000};
      lats = '{1, 1, NORMAL_LAT, NORMAL_LAT};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         issue(ops[i], 32'h8000_0000, 32'hFFFF_FFFF);
         wait_out(lat, rdy_seen);
         e = exp_q.pop_front();
         checks++;
         if (y !== e || lat != lats[i]) begin
            errors++;
            $display("[TB] FAIL overflow[%0d]: got y=%h lat=%0d expected y=%h lat=%0d",
                     i, y, lat, e, lats[i]);
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      int unstable;
      exp_q.push_back(32'd333);
      issue(OP_DIVU, 32'd1000, 32'd3);
      wait_out(lat, rdy_seen);
      e = exp_q.pop_front();
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         if (!out_valid || y !== e) unstable++;
         step();
      end
      checks++;
      if (unstable != 0 || y !== e) begin
         errors++;
         $display("[TB] FAIL backpressure_hold: got %0d unstable cycles y=%h expected 0 y=%h",
                  unstable, y, e);
      end
      // in_valid alongside the releasing handshake must not be accepted.
      in_valid  = 1'b1;
      op        = OP_DIVU;
      a         = 32'd5;
      b         = 32'd1;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL backpressure_release: got rdy/ov/busy=%b expected 100",
                  {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_abort();
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      int seen;
      issue(OP_DIVU, 32'd12345, 32'd7);
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL flush_idle: got rdy/ov/busy=%b expected 100", {in_ready, out_valid, busy});
      end
      issue(OP_DIV, 32'hFFFF_0000, 32'd3);
      repeat (19) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || y !== '0) begin
         errors++;
         $display("[TB] FAIL reset_abort: got rdy/ov/busy=%b y=%h expected 100 y=0",
                  {in_ready, out_valid, busy}, y);
      end
      // flush wins over an accept in the same cycle
      op       = OP_DIVU;
      a        = 32'd9;
      b        = 32'd0;
      in_valid = 1'b1;
      flush    = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      seen = 0;
      repeat (40) begin
         if (out_valid || busy) seen++;
         step();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_result: got %0d active cycles expected 0", seen);
      end
      exp_q.push_back(32'hFFFF_FFFF);
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
      wait_out(lat, rdy_seen);
      e = exp_q.pop_front();
      checks++;
      if (y !== e || lat != NORMAL_LAT) begin
         errors++;
         $display("[TB] FAIL post_abort: got y=%h lat=%0d expected y=%h lat=%0d", y, lat, e, NORMAL_LAT);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      logic [1:0]       o;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] z;
      logic [WIDTH-1:0] e;
      int lat;
      bit rdy_seen;
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         o = 2'(i);
         x = $urandom;
         z = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i % 5 == 4) x = -x;
         exp_q.push_back(model(o, x, z));
         issue(o, x, z);
         wait_out(lat, rdy_seen);
         if (exp_q.size() == 0) begin
            bad++;
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (y !== e || !out_valid) begin
               errors++;
               $display("[TB] FAIL b2b[%0d]: op=%0d a=%h b=%h got %h expected %h", i, o, x, z, y, e);
            end
         end
         release_out();
      end
      checks++;
      if (bad != 0 || exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: got %0d underflows %0d leftovers expected 0 0", bad, exp_q.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_backpressure();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
